input_conditioner: RTL and testbench

Front-end conditioning stage for the Lab 11 sequence-detector FSMs. It takes the raw board switch and pushbuttons and makes each one clean and synchronous:

- each input is synchronized to the 100 MHz system clock, then debounced;
- the centre button becomes a one-cycle `step_pulse` that the downstream one-hot and binary FSMs use as their clock enable;
- it also emits a clean `w` level and a debounced reset request.

---
 rtl/lab11_pkg.sv | 11 +
 rtl/debounce_channel.sv | 58 +++++
 rtl/input_conditioner.sv | 95 +++++++++
 tb/tb_input_conditioner.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lab11_pkg.sv
// Shared constants for the Lab 11 sequence-detector front end.
//   DEBOUNCE_CYCLES_HW  : 10 ms at 100 MHz, used on the board
//   DEBOUNCE_CYCLES_SIM : short window so simulations stay fast
//   STEP_CNT_W          : width of the step counter
package lab11_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_HW  = 1_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
    localparam int unsigned STEP_CNT_W          = 8;

endpackage

// File: rtl/debounce_channel.sv
// One conditioning channel: 2-flop synchronizer followed by a debouncer.
// A change on the synchronized sample is accepted only after it has held
// for DEBOUNCE_CYCLES consecutive cycles; one cycle of agreement restarts
// the count.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   raw   : asynchronous raw input
//   q     : accepted (debounced) level
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_q;
    logic             acc_d;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            acc_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign q = acc_q;

endmodule

// File: rtl/input_conditioner.sv
// Front-end conditioning for the Lab 11 FSMs: debounces the switch and two
// buttons, turns the step button into a one-cycle clock-enable pulse and
// counts the pulses issued.
// Ports:
//   clk        : 100 MHz system clock
//   reset      : asynchronous, active-low reset
//   sw_raw     : raw slide switch (FSM input w)
//   btnC_raw   : raw step button
//   btnU_raw   : raw user-reset button
//   w          : debounced switch level
//   step_pulse : one-cycle pulse per accepted step press
//   reset_req  : debounced user-reset level (FSM synchronous reset)
//   step_count : pulses issued since reset, wraps 255 -> 0
module input_conditioner
    import lab11_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_raw,
    input  logic                  btnC_raw,
    input  logic                  btnU_raw,
    output logic                  w,
    output logic                  step_pulse,
    output logic                  reset_req,
    output logic [STEP_CNT_W-1:0] step_count
);

    logic                  btn_c_q;
    logic                  btn_c_dly_q;
    logic                  step_pulse_q;
    logic                  step_pulse_d;
    logic [STEP_CNT_W-1:0] step_count_q;
    logic [STEP_CNT_W-1:0] step_count_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sw (
        .clk   (clk),
        .reset (reset),
        .raw   (sw_raw),
        .q     (w)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_c (
        .clk   (clk),
        .reset (reset),
        .raw   (btnC_raw),
        .q     (btn_c_q)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_u (
        .clk   (clk),
        .reset (reset),
        .raw   (btnU_raw),
        .q     (reset_req)
    );

    // The delayed copy follows btn_c_q unconditionally, so a press swallowed
    // while reset_req is high is already "seen" and cannot fire later.
    always_comb begin
        step_pulse_d = btn_c_q & ~btn_c_dly_q & ~reset_req;
        step_count_d = step_count_q;
        if (reset_req) begin
            step_count_d = '0;
        end else if (step_pulse_q) begin
            step_count_d = step_count_q + STEP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_c_dly_q  <= 1'b0;
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            btn_c_dly_q  <= btn_c_q;
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
    import lab11_pkg::*;

    localparam int unsigned N = DEBOUNCE_CYCLES_SIM;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_raw;
    logic       btnC_raw;
    logic       btnU_raw;
    logic       w;
    logic       step_pulse;
    logic       reset_req;
    logic [7:0] step_count;

    int n_checks = 0;
    int n_fails  = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .btnC_raw   (btnC_raw),
        .btnU_raw   (btnU_raw),
        .w          (w),
        .step_pulse (step_pulse),
        .reset_req  (reset_req),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; samples are taken 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full press and release, each held well beyond N+3 cycles.
    task automatic press();
        btnC_raw = 1'b1;
        repeat (8) tick();
        btnC_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        reset    = 1'b0;
        sw_raw   = 1'b0;
        btnC_raw = 1'b0;
        btnU_raw = 1'b0;
        repeat (3) tick();
        check_val("rst_w", w, 0);
        check_val("rst_reset_req", reset_req, 0);
        check_val("rst_step_pulse", step_pulse, 0);
        check_val("rst_step_count", step_count, 0);
        reset = 1'b1;
        tick();

        // 1. Clean press: pulse only between edges 7 and 8.
        btnC_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val($sformatf("clean_pulse_e%0d", k), step_pulse, (k == 7) ? 1 : 0);
        end
        check_val("clean_count", step_count, 1);
        btnC_raw = 1'b0;
        repeat (10) tick();
        check_val("clean_release_count", step_count, 1);

        // 2. Bounce 1,1,0,1,1,...: count restarts, single pulse at edge 10.
        for (int k = 1; k <= 14; k++) begin
            btnC_raw = (k == 3) ? 1'b0 : 1'b1;
            tick();
            check_val($sformatf("bounce_pulse_e%0d", k), step_pulse, (k == 10) ? 1 : 0);
        end
        check_val("bounce_count", step_count, 2);

        // 3a. Short switch glitch is rejected.
        sw_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) sw_raw = 1'b0;
            tick();
            check_val($sformatf("glitch_w_e%0d", k), w, 0);
        end
        // 3b. Held switch rises at edge 6.
        sw_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val($sformatf("sw_w_e%0d", k), w, (k >= 6) ? 1 : 0);
        end
        // 3c. Button release gives no pulse.
        btnC_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val($sformatf("release_pulse_e%0d", k), step_pulse, 0);
        end
        check_val("release_count", step_count, 2);

        // 4. Reset priority.
        repeat (3) press();
        check_val("pre_rr_count", step_count, 5);
        btnU_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_val($sformatf("rr_level_e%0d", k), reset_req, (k >= 6) ? 1 : 0);
            if (k == 6) check_val("rr_count_e6", step_count, 5);
        end
        check_val("rr_count_e7", step_count, 0);
        btnC_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val($sformatf("rr_press_pulse_e%0d", k), step_pulse, 0);
        end
        btnU_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_val($sformatf("rr_fall_pulse_e%0d", k), step_pulse, 0);
        end
        check_val("rr_fall_level", reset_req, 0);
        check_val("rr_fall_count", step_count, 0);
        btnC_raw = 1'b0;
        repeat (8) tick();

        // 5a. Wrap after 256 presses.
        for (int p = 1; p <= 256; p++) begin
            press();
            if (p == 255) check_val("wrap_count_255", step_count, 255);
        end
        check_val("wrap_count_0", step_count, 0);
        press();
        check_val("post_wrap_count", step_count, 1);
        check_val("pre_async_w", w, 1);

        // 5b. Async reset mid-debounce (cnt == 2 after edge 4).
        btnC_raw = 1'b1;
        repeat (4) tick();
        check_val("mid_cnt", dut.u_btn_c.cnt_q, 2);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_w", w, 0);
        check_val("async_reset_req", reset_req, 0);
        check_val("async_step_pulse", step_pulse, 0);
        check_val("async_step_count", step_count, 0);
        check_val("async_cnt", dut.u_btn_c.cnt_q, 0);
        tick();
        reset = 1'b1;
        // Held only 3 cycles after release: no pulse.
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) btnC_raw = 1'b0;
            tick();
            check_val($sformatf("short_pulse_e%0d", k), step_pulse, 0);
        end
        check_val("short_count", step_count, 0);

        // Held through reset release: fresh press after full latency.
        btnC_raw = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val($sformatf("held_pulse_e%0d", k), step_pulse, (k == 7) ? 1 : 0);
        end
        check_val("held_count", step_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
